// File: rtl/sdram_ex_pkg.sv
// Shared definitions for the SDRAM example traffic path: default Galois taps
// per width and the multi-step LFSR advance used by generator and checker.
package sdram_ex_pkg;

  localparam logic [7:0]  PRBS_TAPS_W8  = 8'h1D;
  localparam logic [15:0] PRBS_TAPS_W16 = 16'h002D;
  localparam logic [31:0] PRBS_TAPS_W32 = 32'h000000C5;
  localparam int          PRBS_MAX_W    = 32;

  // Applies the Galois step 'steps' times to the low 'width' bits of state.
  // The loop bound is fixed so the function unrolls to pure combinational XORs.
  function automatic logic [31:0] prbs_advance(input logic [31:0] state,
                                               input logic [31:0] taps,
                                               input int          steps,
                                               input int          width);
    logic [31:0] s;
    logic [31:0] mask;
    logic        msb;
    mask = (width >= PRBS_MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
    s    = state & mask;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i < steps) begin
        msb = s[5'(width - 1)];
        s   = ((s << 1) & mask) ^ (msb ? (taps & mask) : 32'd0);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/sdram_ex_prbs_gen_chk_if.sv
// Pattern generator / checker bus: generator controls, read-back compare
// stream and error statistics.
interface sdram_ex_prbs_gen_chk_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
);
  logic                 enable;
  logic                 pause;
  logic                 load;
  logic [WIDTH-1:0]     ldata;
  logic                 ready;
  logic [WIDTH-1:0]     data;
  logic                 chk_valid;
  logic [WIDTH-1:0]     chk_data;
  logic                 chk_sync;
  logic                 err_clear;
  logic                 err;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WIDTH-1:0]     first_err_got;
  logic [WIDTH-1:0]     first_err_exp;

  modport master (
    output enable, pause, load, ldata, ready,
    output chk_valid, chk_data, chk_sync, err_clear,
    input  data, err, err_sticky, err_count, first_err_got, first_err_exp
  );

  modport slave (
    input  enable, pause, load, ldata, ready,
    input  chk_valid, chk_data, chk_sync, err_clear,
    output data, err, err_sticky, err_count, first_err_got, first_err_exp
  );
endinterface

// File: rtl/sdram_ex_prbs_lfsr.sv
// Galois LFSR state register with synchronous reseed, load and multi-step
// advance; priority is enable-low reseed, then load, then advance.
module sdram_ex_prbs_lfsr
  import sdram_ex_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter logic [31:0] TAPS  = 32'(PRBS_TAPS_W8),
  parameter logic [31:0] SEED  = 32'd32,
  parameter int          STEPS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  logic [WIDTH-1:0] nxt;

  assign nxt = WIDTH'(prbs_advance(32'(state), TAPS, STEPS, WIDTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     state <= SEED_W;
    else if (!enable) state <= SEED_W;
    else if (load)    state <= ldata;
    else if (advance) state <= nxt;
  end

endmodule

// File: rtl/sdram_ex_prbs_gen_chk.sv
// PRBS write-data generator plus read-back checker with error statistics.
// Both sides use the same LFSR so the checker can track the generator stream.
module sdram_ex_prbs_gen_chk
  import sdram_ex_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] TAPS      = 32'(PRBS_TAPS_W8),
  parameter logic [31:0] SEED      = 32'd32,
  parameter int          STEPS     = 1,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sdram_ex_prbs_gen_chk_if.slave   bus
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] chk_exp;
  logic [WIDTH-1:0] sync_val;
  logic             mismatch;

  sdram_ex_prbs_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .STEPS (STEPS)
  ) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (bus.enable),
    .load    (bus.load),
    .advance (bus.ready & ~bus.pause),
    .ldata   (bus.ldata),
    .state   (bus.data)
  );

  // A sync word is itself taken as correct, so the checker jumps to its successor.
  assign sync_val = WIDTH'(prbs_advance(32'(bus.chk_data), TAPS, STEPS, WIDTH));

  sdram_ex_prbs_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED),
    .STEPS (STEPS)
  ) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (bus.enable),
    .load    (bus.chk_valid & bus.chk_sync),
    .advance (bus.chk_valid & ~bus.chk_sync),
    .ldata   (sync_val),
    .state   (chk_exp)
  );

  assign mismatch = bus.chk_valid & ~bus.chk_sync & (bus.chk_data != chk_exp);

  // err always reflects the mismatch; a same-cycle clear only suppresses the stats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.err           <= 1'b0;
      bus.err_sticky    <= 1'b0;
      bus.err_count     <= '0;
      bus.first_err_got <= '0;
      bus.first_err_exp <= '0;
    end else begin
      bus.err <= mismatch;
      if (bus.err_clear) begin
        bus.err_sticky    <= 1'b0;
        bus.err_count     <= '0;
        bus.first_err_got <= '0;
        bus.first_err_exp <= '0;
      end else if (mismatch) begin
        if (bus.err_count != CNT_MAX) bus.err_count <= bus.err_count + ERR_CNT_W'(1);
        if (!bus.err_sticky) begin
          bus.err_sticky    <= 1'b1;
          bus.first_err_got <= bus.chk_data;
          bus.first_err_exp <= chk_exp;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_ex_prbs_gen_chk.sv
// Bench for sdram_ex_prbs_gen_chk: table-driven generator vectors, directed
// checker sequences on three parameterisations, and a randomized scoreboard run.
module tb_sdram_ex_prbs_gen_chk;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdram_ex_prbs_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(16)) if_a ();
  sdram_ex_prbs_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(16)) if_b ();
  sdram_ex_prbs_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(2))  if_c ();

  sdram_ex_prbs_gen_chk dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  sdram_ex_prbs_gen_chk #(.STEPS(2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  sdram_ex_prbs_gen_chk #(.ERR_CNT_W(2)) dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  typedef struct {
    logic       en;
    logic       rdy;
    logic       ps;
    logic       ld;
    logic [7:0] ldat;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] ex [0:15];
  logic [7:0] mg, me, mfg, mfe, old_e;
  logic       mst, merr, mis;
  int         mcnt;
  logic       r_en, r_rdy, r_ps, r_ld, r_cv, r_cs, r_clr;
  logic [7:0] r_ldat, r_cd;

  // Spec step rule in plain arithmetic: double, and fold the carry-out back via the taps.
  function automatic logic [7:0] m_adv(input logic [7:0] s, input int steps);
    int v;
    v = int'(s);
    for (int i = 0; i < steps; i++) begin
      v = v * 2;
      if (v >= 256) v = (v - 256) ^ 'h1D;
    end
    return 8'(v);
  endfunction

  function automatic vec_t v(input logic en, input logic rdy, input logic ps,
                             input logic ld, input logic [7:0] ldat, input logic [7:0] ed);
    vec_t r;
    r.en = en; r.rdy = rdy; r.ps = ps; r.ld = ld; r.ldat = ldat; r.exp_data = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic quiet();
    if_a.enable = 0; if_a.pause = 0; if_a.load = 0; if_a.ldata = 0; if_a.ready = 0;
    if_a.chk_valid = 0; if_a.chk_data = 0; if_a.chk_sync = 0; if_a.err_clear = 0;
    if_b.enable = 0; if_b.pause = 0; if_b.load = 0; if_b.ldata = 0; if_b.ready = 0;
    if_b.chk_valid = 0; if_b.chk_data = 0; if_b.chk_sync = 0; if_b.err_clear = 0;
    if_c.enable = 0; if_c.pause = 0; if_c.load = 0; if_c.ldata = 0; if_c.ready = 0;
    if_c.chk_valid = 0; if_c.chk_data = 0; if_c.chk_sync = 0; if_c.err_clear = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    quiet();
    repeat (2) @(negedge clk);

    // Reset values on every instance
    chk("rst a data", 32'(if_a.data), 32'h20);
    chk("rst a err", 32'(if_a.err), 32'h0);
    chk("rst a sticky", 32'(if_a.err_sticky), 32'h0);
    chk("rst a count", 32'(if_a.err_count), 32'h0);
    chk("rst a got", 32'(if_a.first_err_got), 32'h0);
    chk("rst a exp", 32'(if_a.first_err_exp), 32'h0);
    chk("rst b data", 32'(if_b.data), 32'h20);
    chk("rst c count", 32'(if_c.err_count), 32'h0);
    reset_n = 1'b1;

    // Generator vectors: sequence, pause, reseed, load, zero lockup, priorities
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h1D));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3A));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h74));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hE8));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hCD));
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hCD));
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hCD));
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hCD));
    tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'hA5));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h57));
    tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h57));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h20));
    tbl.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40));
    foreach (tbl[i]) begin
      if_a.enable = tbl[i].en; if_a.ready = tbl[i].rdy; if_a.pause = tbl[i].ps;
      if_a.load = tbl[i].ld; if_a.ldata = tbl[i].ldat;
      @(negedge clk);
      chk($sformatf("vec %0d data", i), 32'(if_a.data), 32'(tbl[i].exp_data));
    end
    quiet();

    // Checker resync: sync on 0x74, then 0xE8 and 0xCD must compare clean
    pulse_reset();
    if_a.enable = 1; if_a.chk_valid = 1; if_a.chk_sync = 1; if_a.chk_data = 8'h74;
    @(negedge clk);
    chk("sync err", 32'(if_a.err), 32'h0);
    if_a.chk_sync = 0; if_a.chk_data = 8'hE8;
    @(negedge clk);
    chk("sync e8 err", 32'(if_a.err), 32'h0);
    if_a.chk_data = 8'hCD;
    @(negedge clk);
    chk("sync cd err", 32'(if_a.err), 32'h0);
    if_a.chk_valid = 0;
    @(negedge clk);
    chk("sync count", 32'(if_a.err_count), 32'h0);
    chk("sync sticky", 32'(if_a.err_sticky), 32'h0);
    quiet();

    // Loopback with the 4th word corrupted
    pulse_reset();
    ex[0] = 8'h20;
    for (int k = 1; k < 16; k++) ex[k] = m_adv(ex[k-1], 1);
    if_a.enable = 1; if_a.ready = 1; if_a.chk_valid = 1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("loop data %0d", k), 32'(if_a.data), 32'(ex[k]));
      if (k > 0) chk($sformatf("loop err %0d", k), 32'(if_a.err), 32'(k == 4));
      if_a.chk_data = (k == 3) ? 8'h1C : if_a.data;
      @(negedge clk);
    end
    chk("loop err last", 32'(if_a.err), 32'h0);
    chk("loop count", 32'(if_a.err_count), 32'h1);
    chk("loop sticky", 32'(if_a.err_sticky), 32'h1);
    chk("loop first exp", 32'(if_a.first_err_exp), 32'h1D);
    chk("loop first got", 32'(if_a.first_err_got), 32'h1C);

    // Asynchronous reset mid-stream
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("arst data", 32'(if_a.data), 32'h20);
    chk("arst err", 32'(if_a.err), 32'h0);
    chk("arst count", 32'(if_a.err_count), 32'h0);
    chk("arst sticky", 32'(if_a.err_sticky), 32'h0);
    chk("arst got", 32'(if_a.first_err_got), 32'h0);
    chk("arst exp", 32'(if_a.first_err_exp), 32'h0);
    quiet();
    @(negedge clk); reset_n = 1'b1;

    // STEPS=2 loopback: generator jumps two steps, checker follows cleanly
    if_b.enable = 1; if_b.ready = 1; if_b.chk_valid = 1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s2 data %0d", k), 32'(if_b.data), 32'(ex[2*k]));
      if (k > 0) chk($sformatf("s2 err %0d", k), 32'(if_b.err), 32'h0);
      if_b.chk_data = if_b.data;
      @(negedge clk);
    end
    chk("s2 count", 32'(if_b.err_count), 32'h0);
    quiet();

    // ERR_CNT_W=2: saturation, clear against a mismatch, fresh capture
    pulse_reset();
    if_c.enable = 1; if_c.chk_valid = 1; if_c.chk_data = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("sat err %0d", k), 32'(if_c.err), 32'h1);
      chk($sformatf("sat count %0d", k), 32'(if_c.err_count), 32'((k < 3) ? k + 1 : 3));
    end
    chk("sat first got", 32'(if_c.first_err_got), 32'h00);
    chk("sat first exp", 32'(if_c.first_err_exp), 32'h20);
    if_c.err_clear = 1;
    @(negedge clk);
    chk("clr err", 32'(if_c.err), 32'h1);
    chk("clr count", 32'(if_c.err_count), 32'h0);
    chk("clr sticky", 32'(if_c.err_sticky), 32'h0);
    chk("clr first exp", 32'(if_c.first_err_exp), 32'h0);
    if_c.err_clear = 0; if_c.chk_data = 8'h55;
    @(negedge clk);
    chk("recap count", 32'(if_c.err_count), 32'h1);
    chk("recap sticky", 32'(if_c.err_sticky), 32'h1);
    chk("recap got", 32'(if_c.first_err_got), 32'h55);
    chk("recap exp", 32'(if_c.first_err_exp), 32'(ex[6]));
    quiet();

    // Randomized run against the behavioural model
    pulse_reset();
    mg = 8'h20; me = 8'h20; mfg = 0; mfe = 0; mst = 0; merr = 0; mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd data", 32'(if_a.data), 32'(mg));
      chk("rnd err", 32'(if_a.err), 32'(merr));
      chk("rnd count", 32'(if_a.err_count), 32'(mcnt));
      chk("rnd sticky", 32'(if_a.err_sticky), 32'(mst));
      chk("rnd got", 32'(if_a.first_err_got), 32'(mfg));
      chk("rnd exp", 32'(if_a.first_err_exp), 32'(mfe));
      r_en   = ($urandom_range(0, 19) != 0);
      r_rdy  = ($urandom_range(0, 3) != 0);
      r_ps   = ($urandom_range(0, 3) == 0);
      r_ld   = ($urandom_range(0, 15) == 0);
      r_ldat = 8'($urandom);
      r_cv   = r_en && ($urandom_range(0, 3) != 0);
      r_cs   = ($urandom_range(0, 9) == 0);
      r_cd   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : me;
      r_clr  = ($urandom_range(0, 39) == 0);
      if_a.enable = r_en; if_a.ready = r_rdy; if_a.pause = r_ps; if_a.load = r_ld;
      if_a.ldata = r_ldat; if_a.chk_valid = r_cv; if_a.chk_sync = r_cs;
      if_a.chk_data = r_cd; if_a.err_clear = r_clr;
      mis   = r_cv && !r_cs && (r_cd != me);
      old_e = me;
      if (!r_en) me = 8'h20;
      else if (r_cv && r_cs) me = m_adv(r_cd, 1);
      else if (r_cv) me = m_adv(me, 1);
      if (!r_en) mg = 8'h20;
      else if (r_ld) mg = r_ldat;
      else if (r_rdy && !r_ps) mg = m_adv(mg, 1);
      merr = mis;
      if (r_clr) begin
        mcnt = 0; mst = 0; mfg = 0; mfe = 0;
      end else if (mis) begin
        if (mcnt < 65535) mcnt++;
        if (!mst) begin mst = 1; mfg = r_cd; mfe = old_e; end
      end
      @(negedge clk);
    end
    quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_ex_prbs_gen_chk.md
# sdram_ex_prbs_gen_chk

Parametrised pseudo-random pattern generator and checker for the SDRAM controller example traffic path. The generator produces write data and addresses from a Galois LFSR of configurable width, taps and step count. The checker independently regenerates the expected sequence, compares read-back data and accumulates error statistics. With default parameters the generator sequence is bit-identical to the existing 8-bit example LFSR (seed 32, polynomial x^8+x^4+x^3+x^2+1).

## Interface
- WIDTH, 8, LFSR and data width in bits, 4..32
- TAPS, 8'h1D, Galois feedback mask of WIDTH bits; bit 0 must be set
- SEED, 32, reset/reseed value, truncated to WIDTH; must be nonzero
- STEPS, 1, LFSR shifts per advance, 1..WIDTH
- ERR_CNT_W, 16, error counter width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  0 = hold both LFSRs at SEED (synchronous reseed)
- pause  in  1  1 = freeze generator
- load  in  1  load generator state from ldata
- ldata  in  WIDTH  generator load value
- ready  in  1  consumer accepts data this cycle
- data  out  WIDTH  current generator state (registered)
- chk_valid  in  1  chk_data is valid this cycle
- chk_data  in  WIDTH  read-back word
- chk_sync  in  1  with chk_valid: resynchronise checker to chk_data, no compare
- err_clear  in  1  synchronous clear of error statistics
- err  out  1  one-cycle pulse: a mismatch was detected
- err_sticky  out  1  set on the first error, held until clear
- err_count  out  ERR_CNT_W  saturating mismatch count
- first_err_got  out  WIDTH  chk_data of the first mismatch
- first_err_exp  out  WIDTH  expected word of the first mismatch

## Operation
- Step function: nxt(s) = {s[WIDTH-2:0],0} ^ (s[WIDTH-1] ? TAPS : 0). One advance applies nxt STEPS times combinationally.
- Generator priority per cycle, highest first:
  - reset_n low: state = SEED.
  - enable low: state = SEED.
  - load: state = ldata.
  - ready high and pause low: state advances.
  - Otherwise: state holds.
- Checker expected register exp:
  - Reset or enable low: exp = SEED.
  - chk_valid with chk_sync: exp = advance(chk_data). No compare; err does not pulse.
  - chk_valid without chk_sync: compare chk_data against exp, then exp = advance(exp). Advance occurs regardless of match.
  - pause, load and ready do not affect the checker.
- Mismatch handling:
  - err pulses high.
  - err_count increments and saturates at 2^ERR_CNT_W-1.
  - If err_sticky was 0: capture first_err_got and first_err_exp, then set err_sticky.
- err_clear:
  - Zeroes err_count, err_sticky and both capture registers.
  - Clear wins over a simultaneous mismatch: the count stays 0 and nothing is captured, but err still pulses.
- enable low does not clear the error statistics.
- The all-zero state is a lockup; loading zero through ldata is permitted and holds at zero. The bench checks this case.

## Timing
- All outputs are registered.
- Reset values: data = SEED, err = 0, err_sticky = 0, err_count = 0, capture registers = 0.
- Generator: the advance, load or reseed is visible on data in the cycle after the qualifying edge.
- Checker: err, err_count, err_sticky and the captures update one cycle after the chk_valid cycle.
- Back-to-back chk_valid is supported every cycle; throughput is one word per clock.
- Asynchronous reset mid-sequence returns all state to reset values immediately; there is no recovery sequence.

## Structure
- Shared package sdram_ex_pkg holds:
  - the default TAPS constants per width: 8'h1D, 16'h002D, 32'h000000C5;
  - the function prbs_advance(state, taps, steps).
- One sub-module, sdram_ex_prbs_lfsr, implements the state register, step logic, enable, load and advance. It is instantiated twice:
  - generator: advance = ready & ~pause;
  - checker: load = chk_sync & chk_valid, advance = chk_valid & ~chk_sync. Its load value is advance(chk_data).

## Test plan
- Reset release, then enable=1, ready=1, defaults: data sequence 0x20, 0x40, 0x80, 0x1D, 0x3A, 0x74, 0xE8, 0xCD.
- Pause for 3 cycles while ready=1, then deassert enable: data holds through the pause, then returns to 0x20 the next cycle. Load ldata=0xA5: next cycle data=0xA5.
- STEPS=2, defaults otherwise: data sequence 0x20, 0x80, 0x3A, 0xE8. Checker fed the same stream: err stays 0 and err_count stays 0.
- Loopback with the 4th word corrupted (expected 0x1D, sent 0x1C): err pulses once, err_count=1, first_err_exp=0x1D, first_err_got=0x1C, err_sticky=1. Later words compare clean.
- ERR_CNT_W=2 with continuous mismatches: err_count saturates at 3. err_clear together with a mismatch: count=0 and err pulses. The next mismatch gives count=1 and a new capture.
- chk_sync with chk_data=0x74, then chk_valid with 0xE8 and 0xCD: no errors. Asynchronous reset mid-stream: all outputs return to reset values immediately.
